// File: rtl/embedded_system_nios2_oci_dct_pkg.sv
// Shared constants for the OCI dct producer/consumer pair: packet geometry
// and the flush FSM encodings.
package embedded_system_nios2_oci_dct_pkg;

  localparam int SLOT_W = 2;
  localparam int SLOTS  = 15;
  localparam int BUF_W  = SLOT_W * SLOTS;
  localparam int CNT_W  = 4;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_ENDED = 2'd2;

endpackage

// File: rtl/embedded_system_nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-slot dct packets and hands them out over
// valid/ready, with an end-of-test flush that drains the partial packet.
module embedded_system_nios2_oci_dct_packer
  import embedded_system_nios2_oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             atm_valid,
  input  logic [SLOT_W-1:0] atm_code,
  input  logic             flush,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count,
  output logic             dct_valid,
  input  logic             dct_ready,
  output logic             overflow,
  output logic             test_ending,
  output logic             test_has_ended
);

  logic [1:0]       state_reg;
  logic [BUF_W-1:0] acc_reg;
  logic [CNT_W-1:0] acc_cnt_reg;

  logic             out_free, atom_in, acc_full, handoff, accept, merge, drop;
  logic [BUF_W-1:0] acc_plus, pkt_buf;
  logic [CNT_W-1:0] pkt_cnt;
  logic             go_ended;

  always_comb begin
    out_free = !dct_valid || dct_ready;
    atom_in  = atm_valid && (state_reg == ST_RUN);
    acc_full = (acc_cnt_reg == CNT_W'(SLOTS));
    handoff  = out_free &&
               (((state_reg == ST_RUN) &&
                 (acc_full || (atom_in && acc_cnt_reg == CNT_W'(SLOTS - 1)))) ||
                ((state_reg == ST_FLUSH) && (acc_cnt_reg != '0)));
    accept   = atom_in && (!acc_full || handoff);
    // A non-full acc absorbs the atom before any handoff; a full acc hands
    // off as-is and the atom starts the next packet.
    merge    = accept && !acc_full;
    drop     = atom_in && acc_full && !handoff;
    acc_plus = acc_reg | (BUF_W'(atm_code) << {acc_cnt_reg, 1'b0});
    pkt_buf  = merge ? acc_plus : acc_reg;
    pkt_cnt  = merge ? acc_cnt_reg + CNT_W'(1) : acc_cnt_reg;
    go_ended = (state_reg == ST_FLUSH) && (acc_cnt_reg == '0) &&
               (!dct_valid || dct_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg     <= '0;
      acc_cnt_reg <= '0;
    end else if (handoff) begin
      acc_reg     <= (accept && acc_full) ? BUF_W'(atm_code) : '0;
      acc_cnt_reg <= (accept && acc_full) ? CNT_W'(1) : '0;
    end else if (accept) begin
      acc_reg     <= acc_plus;
      acc_cnt_reg <= pkt_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      dct_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (handoff) begin
        dct_buffer <= pkt_buf;
        dct_count  <= pkt_cnt;
        dct_valid  <= 1'b1;
      end else if (dct_ready) begin
        dct_valid  <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_RUN;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: if (flush) begin
          state_reg   <= ST_FLUSH;
          test_ending <= 1'b1;
        end
        ST_FLUSH: if (go_ended) begin
          state_reg      <= ST_ENDED;
          test_has_ended <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
